// File: rtl/stw_vector_sequencer.sv
// Programmable Stop-the-World self-test sequencer for the bisr systolic array.
// Optional STW_AUTO_EXPECT_EN derives the expected word from op1*op2+add.
module stw_vector_sequencer #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int WORD_SIZE   = 16,
    parameter int NUM_VECTORS = 4,
    parameter int TIMEOUT     = 64,
    localparam int IW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
    localparam int CW = $clog2(NUM_VECTORS + 1),
    localparam int PE = ROWS * COLS,
    localparam int FW = $clog2(PE + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CW-1:0]          vec_count,
    input  logic                   vec_wr_en,
    input  logic [IW-1:0]          vec_wr_idx,
    input  logic [4*WORD_SIZE-1:0] vec_wr_data,
    output logic                   STW_test_load_en,
    output logic [WORD_SIZE-1:0]   STW_mult_op1,
    output logic [WORD_SIZE-1:0]   STW_mult_op2,
    output logic [WORD_SIZE-1:0]   STW_add_op,
    output logic [WORD_SIZE-1:0]   STW_expected,
    output logic                   STW_start,
    input  logic                   STW_complete,
    input  logic [PE-1:0]          STW_result_mat,
    output logic                   busy,
    output logic                   done,
    output logic [PE-1:0]          fault_mask,
    output logic [FW-1:0]          fault_count,
    output logic [IW-1:0]          first_fail_vec,
    output logic                   first_fail_valid,
    output logic                   timeout_err
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FIRE, S_WAIT, S_ACCUM, S_DONE
    } state_t;

    state_t state, state_n;

    logic [WORD_SIZE-1:0] op1_t [NUM_VECTORS];
    logic [WORD_SIZE-1:0] op2_t [NUM_VECTORS];
    logic [WORD_SIZE-1:0] add_t [NUM_VECTORS];
`ifndef STW_AUTO_EXPECT_EN
    logic [WORD_SIZE-1:0] exp_t [NUM_VECTORS];
`endif

    logic [CW-1:0] cnt, cnt_in;
    logic [IW-1:0] idx;
    logic [TW-1:0] wcnt;
    logic [PE-1:0] acc, acc_n;
    logic          prev_cpl;
    logic          cpl_edge;
    logic          last_vec;
    logic          active;
    logic          kill;
    logic          to_hit;

    function automatic logic [FW-1:0] popc(input logic [PE-1:0] v);
        popc = '0;
        for (int i = 0; i < PE; i++) popc = popc + FW'(v[i]);
    endfunction

    assign cnt_in   = (vec_count > CW'(NUM_VECTORS)) ? CW'(NUM_VECTORS)
                                                      : vec_count;
    assign cpl_edge = (state == S_WAIT) && !prev_cpl && STW_complete;
    assign last_vec = (CW'(idx) == cnt - CW'(1));
    assign to_hit   = (wcnt == TW'(TIMEOUT - 1));
    assign kill     = abort && (state != S_IDLE);

    always_comb begin
        state_n = state;
        acc_n   = acc;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    acc_n   = '1;
                    state_n = (cnt_in == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD:  state_n = S_FIRE;
            S_FIRE:  state_n = S_WAIT;
            S_WAIT: begin
                if (cpl_edge) begin
                    state_n = S_ACCUM;
                end else if (to_hit) begin
                    acc_n   = '0;
                    state_n = S_DONE;
                end
            end
            S_ACCUM: begin
                acc_n   = acc & STW_result_mat;
                state_n = last_vec ? S_DONE : S_LOAD;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (kill) state_n = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Table is only writable while idle, so a run always sees a stable table.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_VECTORS; i++) begin
                op1_t[i] <= '0;
                op2_t[i] <= '0;
                add_t[i] <= '0;
`ifndef STW_AUTO_EXPECT_EN
                exp_t[i] <= '0;
`endif
            end
        end else if (vec_wr_en && state == S_IDLE) begin
            op1_t[vec_wr_idx] <= vec_wr_data[WORD_SIZE-1:0];
            op2_t[vec_wr_idx] <= vec_wr_data[2*WORD_SIZE-1:WORD_SIZE];
            add_t[vec_wr_idx] <= vec_wr_data[3*WORD_SIZE-1:2*WORD_SIZE];
`ifndef STW_AUTO_EXPECT_EN
            exp_t[vec_wr_idx] <= vec_wr_data[4*WORD_SIZE-1:3*WORD_SIZE];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt              <= '0;
            idx              <= '0;
            wcnt             <= '0;
            acc              <= '0;
            prev_cpl         <= 1'b0;
            fault_mask       <= '0;
            fault_count      <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            timeout_err      <= 1'b0;
        end else if (!kill) begin
            acc <= acc_n;
            if (state == S_IDLE && start) begin
                cnt              <= cnt_in;
                idx              <= '0;
                timeout_err      <= 1'b0;
                first_fail_valid <= 1'b0;
            end
            // History tracks the live level so a level held over is not an edge.
            if (state == S_FIRE) begin
                wcnt     <= '0;
                prev_cpl <= STW_complete;
            end
            if (state == S_WAIT) begin
                wcnt     <= wcnt + TW'(1);
                prev_cpl <= STW_complete;
                if (!cpl_edge && to_hit) timeout_err <= 1'b1;
            end
            if (state == S_ACCUM) begin
                if (!first_fail_valid && acc_n != acc) begin
                    first_fail_vec   <= idx;
                    first_fail_valid <= 1'b1;
                end
                if (!last_vec) idx <= idx + IW'(1);
            end
            if (state_n == S_DONE && state != S_DONE) begin
                fault_mask  <= ~acc_n;
                fault_count <= popc(~acc_n);
            end
        end
    end

    assign active = (state == S_LOAD) || (state == S_FIRE) ||
                    (state == S_WAIT) || (state == S_ACCUM);

    assign STW_test_load_en = (state == S_LOAD);
    assign STW_start        = (state == S_FIRE);
    assign busy             = (state != S_IDLE);
    assign done             = (state == S_DONE);
    assign STW_mult_op1     = active ? op1_t[idx] : '0;
    assign STW_mult_op2     = active ? op2_t[idx] : '0;
    assign STW_add_op       = active ? add_t[idx] : '0;

`ifdef STW_AUTO_EXPECT_EN
    assign STW_expected = active ? (op1_t[idx] * op2_t[idx] + add_t[idx])
                                 : '0;
`else
    assign STW_expected = active ? exp_t[idx] : '0;
`endif

endmodule

// File: tb/tb_stw_vector_sequencer.sv
// Directed bench for stw_vector_sequencer with a small array response model.
module tb_stw_vector_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  vec_count = '0;
    logic        vec_wr_en = 1'b0;
    logic [1:0]  vec_wr_idx = '0;
    logic [63:0] vec_wr_data = '0;
    logic        STW_test_load_en;
    logic [15:0] STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected;
    logic        STW_start;
    logic        STW_complete = 1'b0;
    logic [15:0] STW_result_mat = '1;
    logic        busy, done;
    logic [15:0] fault_mask;
    logic [4:0]  fault_count;
    logic [1:0]  first_fail_vec;
    logic        first_fail_valid, timeout_err;

    int total = 0;
    int bad = 0;

    int          done_at, fires, busy_ab, saw_done, to_prev;
    logic [15:0] ld_op1, ld_exp;

    stw_vector_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vec_count(vec_count), .vec_wr_en(vec_wr_en),
        .vec_wr_idx(vec_wr_idx), .vec_wr_data(vec_wr_data),
        .STW_test_load_en(STW_test_load_en),
        .STW_mult_op1(STW_mult_op1), .STW_mult_op2(STW_mult_op2),
        .STW_add_op(STW_add_op), .STW_expected(STW_expected),
        .STW_start(STW_start), .STW_complete(STW_complete),
        .STW_result_mat(STW_result_mat), .busy(busy), .done(done),
        .fault_mask(fault_mask), .fault_count(fault_count),
        .first_fail_vec(first_fail_vec),
        .first_fail_valid(first_fail_valid), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic wr(input int i, input logic [15:0] o1, o2, ad, ex);
        @(negedge clk);
        vec_wr_idx  = 2'(i);
        vec_wr_data = {ex, ad, o2, o1};
        vec_wr_en   = 1'b1;
        @(negedge clk);
        vec_wr_en = 1'b0;
    endtask

    // Start pulse is cycle 1; the array raises complete lat cycles after
    // it sees STW_start (lat=0: never). Vector 0 passes all PEs.
    task automatic run(input int cnt, input int lat, input logic [15:0] r1v,
                       input int abort_at, input int poke_at,
                       input int wr_at);
        int cd;
        int vi;
        int ld_seen;
        done_at  = -1;
        fires    = 0;
        busy_ab  = -1;
        saw_done = 0;
        to_prev  = -1;
        ld_op1   = 'x;
        ld_exp   = 'x;
        cd       = 0;
        vi       = 0;
        ld_seen  = 0;
        @(negedge clk);
        vec_count = 3'(cnt);
        start     = 1'b1;
        vec_wr_en = (wr_at == 1);
        for (int cyc = 2; cyc <= 200; cyc++) begin
            @(negedge clk);
            start     = 1'b0;
            abort     = 1'b0;
            vec_wr_en = 1'b0;
            if (STW_test_load_en && ld_seen == 0) begin
                ld_op1  = STW_mult_op1;
                ld_exp  = STW_expected;
                ld_seen = 1;
            end
            if (STW_start) begin
                vi           = fires;
                fires        = fires + 1;
                STW_complete = 1'b0;
                cd           = lat;
            end else if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    STW_result_mat = (vi == 0) ? 16'hFFFF : r1v;
                    STW_complete   = 1'b1;
                end
            end
            if (done) begin
                done_at  = cyc;
                saw_done = 1;
                break;
            end
            if (abort_at > 0 && cyc == abort_at + 1) begin
                busy_ab = int'(busy);
                break;
            end
            to_prev = int'(timeout_err);
            if (cyc == abort_at) abort = 1'b1;
            if (cyc == poke_at) start = 1'b1;
            if (cyc == wr_at) vec_wr_en = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        total++;
        if ({busy, done, STW_start, STW_test_load_en} !== 4'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=0000",
                     {busy, done, STW_start, STW_test_load_en});
        end
        total++;
        if ({fault_mask, fault_count, first_fail_valid, timeout_err} !== '0)
        begin
            bad++;
            $display("FAIL reset_status got=%h/%0d/%b/%b want=0",
                     fault_mask, fault_count, first_fail_valid, timeout_err);
        end
        total++;
        if (STW_mult_op1 !== 16'h0) begin
            bad++;
            $display("FAIL reset_op1 got=%h want=0000", STW_mult_op1);
        end
        run(1, 4, 16'hFFFF, -1, -1, -1);
        total++;
        if (ld_op1 !== 16'h0 || ld_exp !== 16'h0) begin
            bad++;
            $display("FAIL reset_table got=%h/%h want=0000/0000",
                     ld_op1, ld_exp);
        end
        total++;
        if (done_at !== 9) begin
            bad++;
            $display("FAIL reset_run_done got=%0d want=9", done_at);
        end
    endtask

    task automatic test_pass;
        wr(0, 16'd4, 16'd3, 16'd1, 16'd13);
        wr(1, 16'd4, 16'd3, 16'd0, 16'd12);
        run(2, 4, 16'hFFFF, -1, -1, -1);
        total++;
        if (done_at !== 16) begin
            bad++;
            $display("FAIL pass_done_at got=%0d want=16", done_at);
        end
        total++;
        if (fires !== 2) begin
            bad++;
            $display("FAIL pass_fires got=%0d want=2", fires);
        end
        total++;
        if (fault_mask !== 16'h0 || fault_count !== 5'd0) begin
            bad++;
            $display("FAIL pass_mask got=%h/%0d want=0000/0",
                     fault_mask, fault_count);
        end
        total++;
        if (first_fail_valid !== 1'b0) begin
            bad++;
            $display("FAIL pass_ffv got=%b want=0", first_fail_valid);
        end
        total++;
        if (ld_op1 !== 16'd4 || ld_exp !== 16'd13) begin
            bad++;
            $display("FAIL pass_load got=%h/%h want=0004/000d",
                     ld_op1, ld_exp);
        end
    endtask

    task automatic test_fault;
        run(2, 4, 16'hFFBF, -1, -1, -1);
        total++;
        if (fault_mask !== 16'h0040 || fault_count !== 5'd1) begin
            bad++;
            $display("FAIL fault_mask got=%h/%0d want=0040/1",
                     fault_mask, fault_count);
        end
        total++;
        if (first_fail_valid !== 1'b1 || first_fail_vec !== 2'd1) begin
            bad++;
            $display("FAIL fault_first got=%b/%0d want=1/1",
                     first_fail_valid, first_fail_vec);
        end
    endtask

    task automatic test_zero;
        run(0, 4, 16'hFFFF, -1, -1, -1);
        total++;
        if (done_at !== 2 || fires !== 0) begin
            bad++;
            $display("FAIL zero_run got=%0d/%0d want=2/0", done_at, fires);
        end
        total++;
        if (fault_mask !== 16'h0 || fault_count !== 5'd0) begin
            bad++;
            $display("FAIL zero_mask got=%h/%0d want=0000/0",
                     fault_mask, fault_count);
        end
    endtask

    task automatic test_timeout;
        run(1, 0, 16'hFFFF, -1, -1, -1);
        total++;
        if (done_at !== 68) begin
            bad++;
            $display("FAIL tmo_done_at got=%0d want=68", done_at);
        end
        total++;
        if (timeout_err !== 1'b1 || to_prev !== 0) begin
            bad++;
            $display("FAIL tmo_flag got=%b prev=%0d want=1 prev=0",
                     timeout_err, to_prev);
        end
        total++;
        if (fault_mask !== 16'hFFFF || fault_count !== 5'd16) begin
            bad++;
            $display("FAIL tmo_mask got=%h/%0d want=ffff/16",
                     fault_mask, fault_count);
        end
        total++;
        if (first_fail_valid !== 1'b0) begin
            bad++;
            $display("FAIL tmo_ffv got=%b want=0", first_fail_valid);
        end
    endtask

    task automatic test_abort;
        run(2, 4, 16'hFFBF, -1, -1, -1);
        total++;
        if (fault_mask !== 16'h0040 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL abort_setup got=%h/%b want=0040/0",
                     fault_mask, timeout_err);
        end
        vec_wr_idx  = 2'd0;
        vec_wr_data = {16'd99, 16'd8, 16'd8, 16'd7};
        run(2, 4, 16'hFFFF, 5, -1, 3);
        total++;
        if (busy_ab !== 0 || saw_done !== 0) begin
            bad++;
            $display("FAIL abort_busy got=%0d/%0d want=0/0",
                     busy_ab, saw_done);
        end
        total++;
        if (fault_mask !== 16'h0040 || fault_count !== 5'd1) begin
            bad++;
            $display("FAIL abort_mask got=%h/%0d want=0040/1",
                     fault_mask, fault_count);
        end
        total++;
        if (STW_mult_op1 !== 16'h0 || STW_start !== 1'b0) begin
            bad++;
            $display("FAIL abort_outs got=%h/%b want=0000/0",
                     STW_mult_op1, STW_start);
        end
        run(1, 4, 16'hFFFF, -1, -1, -1);
        total++;
        if (ld_op1 !== 16'd4 || ld_exp !== 16'd13) begin
            bad++;
            $display("FAIL abort_table got=%h/%h want=0004/000d",
                     ld_op1, ld_exp);
        end
    endtask

    task automatic test_clamp;
        run(7, 4, 16'hFFFF, -1, 4, -1);
        total++;
        if (fires !== 4 || done_at !== 30) begin
            bad++;
            $display("FAIL clamp_run got=%0d/%0d want=4/30", fires, done_at);
        end
        total++;
        if (busy !== 1'b0 || fault_mask !== 16'h0) begin
            bad++;
            $display("FAIL clamp_end got=%b/%h want=0/0000",
                     busy, fault_mask);
        end
    endtask

    task automatic test_wr_start;
        vec_wr_idx  = 2'd0;
        vec_wr_data = {16'd19, 16'd1, 16'd2, 16'd9};
        run(1, 4, 16'hFFFF, -1, -1, 1);
        total++;
        if (ld_op1 !== 16'd9 || ld_exp !== 16'd19) begin
            bad++;
            $display("FAIL wr_start got=%h/%h want=0009/0013",
                     ld_op1, ld_exp);
        end
    endtask

    task automatic test_auto_expect;
        logic [15:0] want;
`ifdef STW_AUTO_EXPECT_EN
        want = 16'h0001;
`else
        want = 16'h0000;
`endif
        wr(0, 16'hFFFF, 16'd2, 16'd3, 16'd0);
        run(1, 4, 16'hFFFF, -1, -1, -1);
        total++;
        if (ld_op1 !== 16'hFFFF || ld_exp !== want) begin
            bad++;
            $display("FAIL auto_expect got=%h/%h want=ffff/%h",
                     ld_op1, ld_exp, want);
        end
    endtask

    initial begin
        test_reset;
        test_pass;
        test_fault;
        test_zero;
        test_timeout;
        test_abort;
        test_clamp;
        test_wr_start;
        test_auto_expect;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
